// File: rtl/iob_fifo_sync_asym.sv
// Synchronous FIFO with different write and read word widths.
// Storage lives in an external asymmetric two-port RAM; this block keeps pointers, level and flags.
module iob_fifo_sync_asym #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W = 4,
  localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MINDATA_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int W_RATIO = W_DATA_W / MINDATA_W,
  localparam int R_RATIO = R_DATA_W / MINDATA_W,
  localparam int W_ADDR_W = ADDR_W - $clog2(W_RATIO),
  localparam int R_ADDR_W = ADDR_W - $clog2(R_RATIO)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_valid,
  output logic                r_empty,
  output logic [ADDR_W:0]     level,
  output logic                ext_w_en,
  output logic [W_ADDR_W-1:0] ext_w_addr,
  output logic [W_DATA_W-1:0] ext_w_data,
  output logic                ext_r_en,
  output logic [R_ADDR_W-1:0] ext_r_addr,
  input  logic [R_DATA_W-1:0] ext_r_data
);

  if ((MAXDATA_W % MINDATA_W) != 0 || (1 << $clog2(MAXDATA_W / MINDATA_W)) != (MAXDATA_W / MINDATA_W)) begin : g_bad_ratio
    $error("iob_fifo_sync_asym: wider port must be a power-of-two multiple of the narrower one");
  end

  localparam logic [ADDR_W:0] W_INC   = (ADDR_W+1)'(W_RATIO);
  localparam logic [ADDR_W:0] R_DEC   = (ADDR_W+1)'(R_RATIO);
  localparam logic [ADDR_W:0] FULL_TH = (ADDR_W+1)'((1 << ADDR_W) - W_RATIO);

  logic [W_ADDR_W-1:0] w_ptr;
  logic [R_ADDR_W-1:0] r_ptr;
  logic                w_acc;
  logic                r_acc;
  logic [ADDR_W:0]     level_next;

  // Acceptance uses the registered flags only, so a same-cycle read never frees room for a write.
  assign w_acc = w_en & ~w_full & ~rst;
  assign r_acc = r_en & ~r_empty & ~rst;

  assign ext_w_en   = w_acc;
  assign ext_w_addr = w_ptr;
  assign ext_w_data = w_data;
  assign ext_r_en   = r_acc;
  assign ext_r_addr = r_ptr;
  assign r_data     = ext_r_data;

  // level + W_INC never exceeds 2^ADDR_W when a write is accepted, so ADDR_W+1 bits suffice.
  always_comb begin
    level_next = level;
    if (w_acc) level_next = level_next + W_INC;
    if (r_acc) level_next = level_next - R_DEC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level   <= '0;
      w_full  <= 1'b0;
      r_empty <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      if (w_acc) w_ptr <= w_ptr + W_ADDR_W'(1);
      if (r_acc) r_ptr <= r_ptr + R_ADDR_W'(1);
      level   <= level_next;
      w_full  <= (level_next > FULL_TH);
      r_empty <= (level_next < R_DEC);
      r_valid <= r_acc;
    end
  end

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: a 32->8 instance and an 8->32 instance, each behind a RAM model.
// Read data is checked by per-instance monitors against queues filled when reads are issued.
module tb_iob_fifo_sync_asym;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 32-bit write, 8-bit read
  logic        w_en0, w_full0, r_en0, r_valid0, r_empty0, ext_w_en0, ext_r_en0;
  logic [31:0] w_data0, ext_w_data0;
  logic [7:0]  r_data0, ext_r_data0;
  logic [4:0]  level0;
  logic [1:0]  ext_w_addr0;
  logic [3:0]  ext_r_addr0;

  // 8-bit write, 32-bit read
  logic        w_en1, w_full1, r_en1, r_valid1, r_empty1, ext_w_en1, ext_r_en1;
  logic [7:0]  w_data1, ext_w_data1;
  logic [31:0] r_data1, ext_r_data1;
  logic [4:0]  level1;
  logic [3:0]  ext_w_addr1;
  logic [1:0]  ext_r_addr1;

  iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut0 (
    .clk(clk), .rst(rst),
    .w_en(w_en0), .w_data(w_data0), .w_full(w_full0),
    .r_en(r_en0), .r_data(r_data0), .r_valid(r_valid0), .r_empty(r_empty0),
    .level(level0),
    .ext_w_en(ext_w_en0), .ext_w_addr(ext_w_addr0), .ext_w_data(ext_w_data0),
    .ext_r_en(ext_r_en0), .ext_r_addr(ext_r_addr0), .ext_r_data(ext_r_data0)
  );

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .w_en(w_en1), .w_data(w_data1), .w_full(w_full1),
    .r_en(r_en1), .r_data(r_data1), .r_valid(r_valid1), .r_empty(r_empty1),
    .level(level1),
    .ext_w_en(ext_w_en1), .ext_w_addr(ext_w_addr1), .ext_w_data(ext_w_data1),
    .ext_r_en(ext_r_en1), .ext_r_addr(ext_r_addr1), .ext_r_data(ext_r_data1)
  );

  // Asymmetric RAM models, byte-granular, lowest byte at lowest unit address
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];

  always @(posedge clk) begin
    if (ext_w_en0)
      for (int k = 0; k < 4; k++) mem0[{ext_w_addr0, k[1:0]}] <= ext_w_data0[8*k +: 8];
    if (ext_r_en0) ext_r_data0 <= mem0[ext_r_addr0];
    if (ext_w_en1) mem1[ext_w_addr1] <= ext_w_data1;
    if (ext_r_en1)
      ext_r_data1 <= {mem1[{ext_r_addr1, 2'd3}], mem1[{ext_r_addr1, 2'd2}],
                      mem1[{ext_r_addr1, 2'd1}], mem1[{ext_r_addr1, 2'd0}]};
  end

  logic [7:0]  q0 [$];
  logic [31:0] q1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (r_valid0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL r_data0_unexpected: got 0x%0h with no read outstanding", r_data0);
      end else begin
        chk("r_data0", {24'h0, r_data0}, {24'h0, q0.pop_front()});
      end
    end
    if (r_valid1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL r_data1_unexpected: got 0x%0h with no read outstanding", r_data1);
      end else begin
        chk("r_data1", r_data1, q1.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [31:0] d);
    w_en0 = 1'b1;
    w_data0 = d;
    cyc();
    w_en0 = 1'b0;
  endtask

  task automatic rd0(input logic [7:0] exp);
    r_en0 = 1'b1;
    q0.push_back(exp);
    #1;
    chk("ext_r_en0", {31'h0, ext_r_en0}, 32'h1);
    cyc();
    r_en0 = 1'b0;
    chk("r_valid0_after_read", {31'h0, r_valid0}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    w_en0 = 1'b1; w_data0 = 32'hDEADBEEF; r_en0 = 1'b0;
    w_en1 = 1'b0; w_data1 = 8'h00; r_en1 = 1'b0;
    #1;
    chk("ext_w_en0_in_reset", {31'h0, ext_w_en0}, 32'h0);
    cyc(); cyc();
    w_en0 = 1'b0;
    chk("rst_level0", {27'h0, level0}, 32'd0);
    chk("rst_w_full0", {31'h0, w_full0}, 32'h0);
    chk("rst_r_empty0", {31'h0, r_empty0}, 32'h1);
    chk("rst_r_valid0", {31'h0, r_valid0}, 32'h0);
    chk("rst_r_empty1", {31'h0, r_empty1}, 32'h1);
    rst = 1'b0;
    cyc();

    // basic byte order
    w_en0 = 1'b1; w_data0 = 32'h44332211;
    #1;
    chk("basic_ext_w_en0", {31'h0, ext_w_en0}, 32'h1);
    chk("basic_ext_w_addr0", {30'h0, ext_w_addr0}, 32'd0);
    cyc();
    w_en0 = 1'b0;
    chk("basic_level_after_wr", {27'h0, level0}, 32'd4);
    chk("basic_r_empty_after_wr", {31'h0, r_empty0}, 32'h0);
    rd0(8'h11); rd0(8'h22); rd0(8'h33); rd0(8'h44);
    chk("basic_level_end", {27'h0, level0}, 32'd0);
    chk("basic_r_empty_end", {31'h0, r_empty0}, 32'h1);
    cyc();
    chk("basic_r_valid_idle", {31'h0, r_valid0}, 32'h0);

    // full
    wr0(32'h43424140); wr0(32'h47464544); wr0(32'h4B4A4948);
    chk("full_w_full_at_12", {31'h0, w_full0}, 32'h0);
    wr0(32'h4F4E4D4C);
    chk("full_level_16", {27'h0, level0}, 32'd16);
    chk("full_w_full_at_16", {31'h0, w_full0}, 32'h1);
    w_en0 = 1'b1; w_data0 = 32'hBADBADBA;
    #1;
    chk("full_drop_ext_w_en0", {31'h0, ext_w_en0}, 32'h0);
    cyc();
    w_en0 = 1'b0;
    chk("full_drop_level", {27'h0, level0}, 32'd16);
    rd0(8'h40);
    chk("full_level_15", {27'h0, level0}, 32'd15);
    chk("full_w_full_at_15", {31'h0, w_full0}, 32'h1);
    rd0(8'h41); rd0(8'h42); rd0(8'h43);
    chk("full_level_12", {27'h0, level0}, 32'd12);
    chk("full_w_full_cleared", {31'h0, w_full0}, 32'h0);

    // simultaneous access at level 8
    rd0(8'h44); rd0(8'h45); rd0(8'h46); rd0(8'h47);
    chk("sim_level_8", {27'h0, level0}, 32'd8);
    chk("sim_w_ptr_before", {30'h0, ext_w_addr0}, 32'd1);
    chk("sim_r_ptr_before", {28'h0, ext_r_addr0}, 32'd12);
    w_en0 = 1'b1; w_data0 = 32'h53525150;
    rd0(8'h48);
    w_en0 = 1'b0;
    chk("sim_level_11", {27'h0, level0}, 32'd11);
    chk("sim_w_ptr_after", {30'h0, ext_w_addr0}, 32'd2);
    chk("sim_r_ptr_after", {28'h0, ext_r_addr0}, 32'd13);
    rd0(8'h49); rd0(8'h4A); rd0(8'h4B); rd0(8'h4C); rd0(8'h4D); rd0(8'h4E); rd0(8'h4F);
    rd0(8'h50); rd0(8'h51); rd0(8'h52); rd0(8'h53);
    chk("sim_drained", {27'h0, level0}, 32'd0);

    // wrap: 10 rounds of one word in, four bytes out
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h60 + 4 * i);
      wr0({b + 8'd3, b + 8'd2, b + 8'd1, b});
      for (int j = 0; j < 4; j++) rd0(b + 8'(j));
    end
    chk("wrap_level_end", {27'h0, level0}, 32'd0);
    chk("wrap_r_empty_end", {31'h0, r_empty0}, 32'h1);

    // underflow
    r_en0 = 1'b1;
    #1;
    chk("uflow_ext_r_en0", {31'h0, ext_r_en0}, 32'h0);
    cyc();
    r_en0 = 1'b0;
    chk("uflow_r_valid0", {31'h0, r_valid0}, 32'h0);
    chk("uflow_level", {27'h0, level0}, 32'd0);

    // reset mid-operation at level 12
    wr0(32'h01020304); wr0(32'h05060708); wr0(32'h090A0B0C);
    chk("rst_mid_level_12", {27'h0, level0}, 32'd12);
    rst = 1'b1; w_en0 = 1'b1; r_en0 = 1'b1;
    #1;
    chk("rst_mid_ext_w_en0", {31'h0, ext_w_en0}, 32'h0);
    chk("rst_mid_ext_r_en0", {31'h0, ext_r_en0}, 32'h0);
    cyc();
    rst = 1'b0; w_en0 = 1'b0; r_en0 = 1'b0;
    chk("rst_mid_level", {27'h0, level0}, 32'd0);
    chk("rst_mid_r_empty", {31'h0, r_empty0}, 32'h1);
    chk("rst_mid_w_full", {31'h0, w_full0}, 32'h0);
    chk("rst_mid_r_valid", {31'h0, r_valid0}, 32'h0);

    // narrow write, wide read
    w_en1 = 1'b1;
    w_data1 = 8'hAA; cyc();
    w_data1 = 8'hBB; cyc();
    w_data1 = 8'hCC; cyc();
    w_en1 = 1'b0;
    chk("n2w_level_3", {27'h0, level1}, 32'd3);
    chk("n2w_r_empty_at_3", {31'h0, r_empty1}, 32'h1);
    w_en1 = 1'b1; w_data1 = 8'hDD; cyc();
    w_en1 = 1'b0;
    chk("n2w_r_empty_at_4", {31'h0, r_empty1}, 32'h0);
    r_en1 = 1'b1;
    q1.push_back(32'hDDCCBBAA);
    #1;
    chk("n2w_ext_r_en1", {31'h0, ext_r_en1}, 32'h1);
    cyc();
    r_en1 = 1'b0;
    chk("n2w_r_valid1", {31'h0, r_valid1}, 32'h1);
    chk("n2w_level_end", {27'h0, level1}, 32'd0);
    cyc(); cyc();

    chk("q0_all_consumed", q0.size(), 32'd0);
    chk("q1_all_consumed", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_fifo_sync_asym.md
IOB_FIFO_SYNC_ASYM -- requirements
Module: iob_fifo_sync_asym

Interface
REQ-001 SHALL have parameter W_DATA_W, default 32, meaning write-side word width in bits.
REQ-002 SHALL have parameter R_DATA_W, default 8, meaning read-side word width in bits.
REQ-003 SHALL have parameter ADDR_W, default 4, meaning log2 of the capacity counted in MINDATA_W units.
REQ-004 SHALL have derived parameters:
- MAXDATA_W/MINDATA_W: max/min of W_DATA_W and R_DATA_W.
- W_RATIO = W_DATA_W/MINDATA_W; R_RATIO = R_DATA_W/MINDATA_W.
- W_ADDR_W = ADDR_W - log2(W_RATIO); R_ADDR_W = ADDR_W - log2(R_RATIO).
- The larger width SHALL be a power-of-two multiple of the smaller.
REQ-005 SHALL have a single clock and a synchronous active-high reset:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-006 SHALL provide these user ports:
- w_en  in  1  write request.
- w_data  in  W_DATA_W  write word.
- w_full  out  1  no room for one write word.
- r_en  in  1  read request.
- r_data  out  R_DATA_W  read word.
- r_valid  out  1  r_data valid this cycle.
- r_empty  out  1  less than one read word stored.
- level  out  ADDR_W+1  occupancy in MINDATA_W units.
REQ-007 SHALL provide these memory-side ports, which connect to the logical ports of the asymmetric two-port RAM:
- ext_w_en  out  1.
- ext_w_addr  out  W_ADDR_W.
- ext_w_data  out  W_DATA_W.
- ext_r_en  out  1.
- ext_r_addr  out  R_ADDR_W.
- ext_r_data  in  R_DATA_W.

Function
REQ-008 SHALL accept a write when w_en=1 and w_full=0; a write with w_full=1 SHALL be dropped with no state change.
REQ-009 SHALL accept a read when r_en=1 and r_empty=0; a read with r_empty=1 SHALL be dropped with no state change.
REQ-010 SHALL drive ext_w_en = accepted write, ext_w_addr = w_ptr, and ext_w_data = w_data, all combinationally.
REQ-011 SHALL drive ext_r_en = accepted read and ext_r_addr = r_ptr, both combinationally.
REQ-012 SHALL use w_ptr (W_ADDR_W bits) and r_ptr (R_ADDR_W bits), each incrementing by 1 per accepted access and wrapping modulo 2^width with no special case.
REQ-013 SHALL update level each cycle by +W_RATIO per accepted write and -R_RATIO per accepted read, and SHALL apply both when both are accepted in the same cycle.
REQ-014 SHALL evaluate acceptance from flags registered at the start of the cycle; a simultaneous read SHALL NOT free space for a same-cycle write, and vice versa.
REQ-015 SHALL register w_full = (level_next > 2^ADDR_W - W_RATIO).
REQ-016 SHALL register r_empty = (level_next < R_RATIO).
REQ-017 SHALL have read latency 1: r_valid=1 exactly in the cycle after an accepted read, and r_data = ext_r_data passed through.
REQ-018 SHALL treat r_data as don't-care when r_valid=0.
REQ-019 SHALL order data least-significant-first:
- W>R: successive reads of one written word return w_data[R_DATA_W-1:0] first, then ascending slices.
- W<R: the first written word lands in r_data[W_DATA_W-1:0].
REQ-020 SHALL behave as a plain synchronous FIFO with ratios of 1 when W_DATA_W = R_DATA_W.
REQ-021 SHALL never exceed 2^ADDR_W in level and never go below 0 in level.
REQ-022 SHALL NOT combinationally path ext_r_data to any flag.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set w_ptr=0, r_ptr=0, level=0, w_full=0, r_empty=1, r_valid=0.
REQ-024 SHALL force ext_w_en=0 and ext_r_en=0 while rst=1.
REQ-025 SHALL, on reset mid-operation, discard all stored data logically; r_valid SHALL be 0 in the cycle after the reset edge even if a read was accepted before it.
REQ-026 SHALL NOT reset RAM contents.

Verification (W_DATA_W=32, R_DATA_W=8, ADDR_W=4 unless noted)
REQ-027 SHALL be checked for basic order: after reset, write 0x44332211, then read 4 times -> r_data 0x11, 0x22, 0x33, 0x44, each with r_valid one cycle after r_en; r_empty=1 and level=0 at end.
REQ-028 SHALL be checked for full: 4 writes -> level=16, w_full=1; a 5th write is dropped (ext_w_en=0, level stays 16); one read -> level=15, w_full stays 1; 4 reads -> w_full=0.
REQ-029 SHALL be checked for simultaneous access: level=8, w_en=r_en=1 for one cycle -> level=11, both pointers advance.
REQ-030 SHALL be checked for wrap: 10 rounds of write 1 word / read 4 bytes with incrementing data -> all 40 bytes in order, and pointers wrap without error.
REQ-031 SHALL be checked for underflow/reset: r_en with r_empty=1 -> ext_r_en=0, r_valid=0 next cycle; rst asserted with level=12 -> level=0, r_empty=1, w_full=0 next cycle.
REQ-032 SHALL be checked with W_DATA_W=8, R_DATA_W=32: writes 0xAA, 0xBB, 0xCC -> r_empty=1; a 4th write 0xDD -> r_empty=0; read -> r_data=0xDDCCBBAA.
